// File: rtl/som_seq_ctrl.sv
// SOM sequencer: multi-epoch training read pass, weight write pass, then mapping pass with delayed result writes.
// Latency: start to first image read is 1 cycle; result writes trail their reads by MAP_LAT cycles; all outputs registered.
// Backpressure: stall freezes state, counters and the map delay line and zeroes every strobe; start is taken only in IDLE/DONE.
module som_seq_ctrl #(
  parameter int ADDR_W    = 18,
  parameter int NUM_IMG   = 2,
  parameter int IMG_WORDS = 20480,
  parameter int NUM_W     = 64,
  parameter int EPOCHS    = 1,
  parameter int MAP_LAT   = 1
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            start,
  input  logic                                            stall,
  output logic                                            busy,
  output logic                                            done,
  output logic [((EPOCHS > 1) ? $clog2(EPOCHS) : 1)-1:0]  epoch,
  output logic                                            w_update,
  output logic                                            lr_step,
  output logic [ADDR_W-1:0]                               ram_if_a,
  output logic                                            ram_if_oe,
  output logic [ADDR_W-1:0]                               ram_w_a,
  output logic                                            ram_w_we,
  output logic [ADDR_W-1:0]                               ram_res_a,
  output logic                                            ram_res_we
);

  localparam int TRAIN_LEN = NUM_IMG * IMG_WORDS;
  localparam int EP_W      = (EPOCHS > 1) ? $clog2(EPOCHS) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_TRAIN = 3'd1;
  localparam logic [2:0] S_WR_W  = 3'd2;
  localparam logic [2:0] S_MAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] IF_LAST = ADDR_W'(TRAIN_LEN - 1);
  localparam logic [ADDR_W-1:0] W_LAST  = ADDR_W'(NUM_W - 1);
  localparam logic [EP_W-1:0]   EP_LAST = EP_W'(EPOCHS - 1);

  logic [2:0]        state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [EP_W-1:0]   epoch_q, epoch_d;
  logic              w_update_q, w_update_d;
  logic              lr_step_q, lr_step_d;
  logic [ADDR_W-1:0] if_a_q, if_a_d;
  logic              if_oe_q, if_oe_d;
  logic [ADDR_W-1:0] w_a_q, w_a_d;
  logic              w_we_q, w_we_d;
  logic [ADDR_W-1:0] res_a_q, res_a_d;
  logic              res_we_q, res_we_d;
  // rd_fin: every MAP read has been issued and pushed into the delay line
  logic              rd_fin_q, rd_fin_d;
  // Map delay line; the last stage is mirrored onto the result port as it shifts in
  logic [MAP_LAT-1:0]             dl_vld_q, dl_vld_d;
  logic [MAP_LAT-1:0][ADDR_W-1:0] dl_a_q, dl_a_d;

  // Next-cycle values: in TRAIN/WR_W/MAP the registered address is the one issued this cycle, so each unstalled edge retires it and issues the next
  always_comb begin
    state_d    = state_q;
    epoch_d    = epoch_q;
    if_a_d     = if_a_q;
    w_a_d      = w_a_q;
    res_a_d    = res_a_q;
    rd_fin_d   = rd_fin_q;
    dl_vld_d   = dl_vld_q;
    dl_a_d     = dl_a_q;
    if_oe_d    = 1'b0;
    w_we_d     = 1'b0;
    res_we_d   = 1'b0;
    w_update_d = 1'b0;
    lr_step_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_TRAIN;
          epoch_d = '0;
          if_a_d  = '0;
          if_oe_d = 1'b1;
        end
      end
      S_TRAIN: begin
        if (!stall) begin
          w_update_d = 1'b1;
          if (if_a_q == IF_LAST) begin
            lr_step_d = 1'b1;
            if (epoch_q == EP_LAST) begin
              state_d = S_WR_W;
              w_a_d   = '0;
              w_we_d  = 1'b1;
            end else begin
              epoch_d = epoch_q + 1'b1;
              if_a_d  = '0;
              if_oe_d = 1'b1;
            end
          end else begin
            if_a_d  = if_a_q + 1'b1;
            if_oe_d = 1'b1;
          end
        end
      end
      S_WR_W: begin
        if (!stall) begin
          if (w_a_q == W_LAST) begin
            state_d  = S_MAP;
            if_a_d   = '0;
            if_oe_d  = 1'b1;
            rd_fin_d = 1'b0;
          end else begin
            w_a_d  = w_a_q + 1'b1;
            w_we_d = 1'b1;
          end
        end
      end
      S_MAP: begin
        if (!stall) begin
          for (int i = 1; i < MAP_LAT; i++) begin
            dl_vld_d[i] = dl_vld_q[i-1];
            dl_a_d[i]   = dl_a_q[i-1];
          end
          dl_vld_d[0] = !rd_fin_q;
          dl_a_d[0]   = if_a_q;
          res_we_d    = dl_vld_d[MAP_LAT-1];
          if (dl_vld_d[MAP_LAT-1]) begin
            res_a_d = dl_a_d[MAP_LAT-1];
          end
          if (!rd_fin_q) begin
            if (if_a_q == IF_LAST) begin
              rd_fin_d = 1'b1;
            end else begin
              if_a_d  = if_a_q + 1'b1;
              if_oe_d = 1'b1;
            end
          end
          // The final result was written this cycle (it sits in the last stage)
          if (dl_vld_q[MAP_LAT-1] && (dl_a_q[MAP_LAT-1] == IF_LAST)) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_TRAIN) || (state_d == S_WR_W) || (state_d == S_MAP);
    done_d = (state_d == S_DONE);
  end

  // State, counters, delay line and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      epoch_q    <= '0;
      w_update_q <= 1'b0;
      lr_step_q  <= 1'b0;
      if_a_q     <= '0;
      if_oe_q    <= 1'b0;
      w_a_q      <= '0;
      w_we_q     <= 1'b0;
      res_a_q    <= '0;
      res_we_q   <= 1'b0;
      rd_fin_q   <= 1'b0;
      dl_vld_q   <= '0;
      dl_a_q     <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      epoch_q    <= epoch_d;
      w_update_q <= w_update_d;
      lr_step_q  <= lr_step_d;
      if_a_q     <= if_a_d;
      if_oe_q    <= if_oe_d;
      w_a_q      <= w_a_d;
      w_we_q     <= w_we_d;
      res_a_q    <= res_a_d;
      res_we_q   <= res_we_d;
      rd_fin_q   <= rd_fin_d;
      dl_vld_q   <= dl_vld_d;
      dl_a_q     <= dl_a_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign epoch      = epoch_q;
  assign w_update   = w_update_q;
  assign lr_step    = lr_step_q;
  assign ram_if_a   = if_a_q;
  assign ram_if_oe  = if_oe_q;
  assign ram_w_a    = w_a_q;
  assign ram_w_we   = w_we_q;
  assign ram_res_a  = res_a_q;
  assign ram_res_we = res_we_q;

endmodule

// File: tb/tb_som_seq_ctrl.sv
// Bench for som_seq_ctrl: two instances (EPOCHS=2/MAP_LAT=1 and EPOCHS=1/MAP_LAT=3) checked every cycle
// against a timeline model indexed by the number of unstalled cycles since start, plus literal expectations.
module tb_som_seq_ctrl;
  localparam int AW = 18;
  localparam int NI = 2;
  localparam int IW = 4;
  localparam int NW = 3;
  localparam int TL = NI * IW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stall_a = 1'b0;
  logic stall_b = 1'b0;

  logic busy_a, done_a, w_update_a, lr_step_a, if_oe_a, w_we_a, res_we_a;
  logic busy_b, done_b, w_update_b, lr_step_b, if_oe_b, w_we_b, res_we_b;
  logic [0:0] epoch_a, epoch_b;
  logic [AW-1:0] if_a_a, w_a_a, res_a_a, if_a_b, w_a_b, res_a_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  som_seq_ctrl #(.ADDR_W(AW), .NUM_IMG(NI), .IMG_WORDS(IW), .NUM_W(NW), .EPOCHS(2), .MAP_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stall(stall_a), .busy(busy_a), .done(done_a), .epoch(epoch_a),
    .w_update(w_update_a), .lr_step(lr_step_a), .ram_if_a(if_a_a), .ram_if_oe(if_oe_a), .ram_w_a(w_a_a),
    .ram_w_we(w_we_a), .ram_res_a(res_a_a), .ram_res_we(res_we_a));

  som_seq_ctrl #(.ADDR_W(AW), .NUM_IMG(NI), .IMG_WORDS(IW), .NUM_W(NW), .EPOCHS(1), .MAP_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stall(stall_b), .busy(busy_b), .done(done_b), .epoch(epoch_b),
    .w_update(w_update_b), .lr_step(lr_step_b), .ram_if_a(if_a_b), .ram_if_oe(if_oe_b), .ram_w_a(w_a_b),
    .ram_w_we(w_we_b), .ram_res_a(res_a_b), .ram_res_we(res_we_b));

  // Model: k = unstalled cycles since start (1 = first read), stl = this cycle is a held cycle
  int m_k[2];
  bit m_stl[2];
  int m_ep[2];
  int m_if_a[2], m_w_a[2], m_res_a[2];
  bit m_busy[2], m_done[2], m_if_oe[2], m_w_we[2], m_res_we[2], m_wu[2], m_lr[2];

  function automatic int ep_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int ml_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int done_k(input int i);
    return ep_of(i) * TL + NW + 1 + TL + ml_of(i);
  endfunction

  task automatic model_eval(input int i);
    int t, m0, ml, k;
    t  = ep_of(i) * TL;
    m0 = t + NW + 1;
    ml = ml_of(i);
    k  = m_k[i];
    m_busy[i] = (k >= 1) && (k < done_k(i));
    m_done[i] = (k >= done_k(i));
    m_if_oe[i] = 0; m_w_we[i] = 0; m_res_we[i] = 0; m_wu[i] = 0; m_lr[i] = 0;
    if (m_busy[i] && !m_stl[i]) begin
      if (k <= t) begin
        m_if_oe[i] = 1; m_if_a[i] = (k - 1) % TL; m_ep[i] = (k - 1) / TL;
      end
      if (k >= m0 && k < m0 + TL) begin
        m_if_oe[i] = 1; m_if_a[i] = k - m0;
      end
      if (k > t && k <= t + NW) begin
        m_w_we[i] = 1; m_w_a[i] = k - t - 1;
      end
      if (k >= m0 + ml && k < m0 + ml + TL) begin
        m_res_we[i] = 1; m_res_a[i] = k - m0 - ml;
      end
      if (k >= 2 && k <= t + 1) begin
        m_wu[i] = 1;
        if ((k - 1) % TL == 0) m_lr[i] = 1;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_k[i] = 0; m_stl[i] = 0; m_ep[i] = 0;
      m_if_a[i] = 0; m_w_a[i] = 0; m_res_a[i] = 0;
      model_eval(i);
    end
  endtask

  task automatic model_step(input int i, input bit st, input bit sl);
    if (m_k[i] == 0 || m_k[i] >= done_k(i)) begin
      m_stl[i] = 0;
      if (st) begin
        m_k[i] = 1; m_ep[i] = 0;
      end
    end else if (sl) begin
      m_stl[i] = 1;
    end else begin
      m_stl[i] = 0; m_k[i] = m_k[i] + 1;
    end
    model_eval(i);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Advance the model on every clock edge, or reset it with the DUT
  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else begin
        model_step(0, start, stall_a);
        model_step(1, start, stall_b);
      end
    end
  end

  // Compare both DUTs against the model every cycle, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      chk("a.busy", int'(busy_a), int'(m_busy[0]));      chk("b.busy", int'(busy_b), int'(m_busy[1]));
      chk("a.done", int'(done_a), int'(done_a === 1'bx ? 2 : m_done[0])); chk("b.done", int'(done_b), int'(m_done[1]));
      chk("a.epoch", int'(epoch_a), m_ep[0]);             chk("b.epoch", int'(epoch_b), m_ep[1]);
      chk("a.w_update", int'(w_update_a), int'(m_wu[0])); chk("b.w_update", int'(w_update_b), int'(m_wu[1]));
      chk("a.lr_step", int'(lr_step_a), int'(m_lr[0]));   chk("b.lr_step", int'(lr_step_b), int'(m_lr[1]));
      chk("a.if_oe", int'(if_oe_a), int'(m_if_oe[0]));    chk("b.if_oe", int'(if_oe_b), int'(m_if_oe[1]));
      chk("a.if_a", int'(if_a_a), m_if_a[0]);             chk("b.if_a", int'(if_a_b), m_if_a[1]);
      chk("a.w_we", int'(w_we_a), int'(m_w_we[0]));       chk("b.w_we", int'(w_we_b), int'(m_w_we[1]));
      chk("a.w_a", int'(w_a_a), m_w_a[0]);                chk("b.w_a", int'(w_a_b), m_w_a[1]);
      chk("a.res_we", int'(res_we_a), int'(m_res_we[0])); chk("b.res_we", int'(res_we_b), int'(m_res_we[1]));
      chk("a.res_a", int'(res_a_a), m_res_a[0]);          chk("b.res_a", int'(res_a_b), m_res_a[1]);
    end
  end

  // Directed stimulus with hand-computed literal expectations (cycle 1 = first read cycle)
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle.busy", int'(busy_a), 0);
    chk("idle.if_oe", int'(if_oe_a), 0);
    chk("idle.if_a", int'(if_a_a), 0);
    chk("idle.res_a", int'(res_a_a), 0);

    // Run 1: full run, start pulse during WR_W ignored
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = (c == 18);
      case (c)
        1: begin
          chk("r1.c1.if_a", int'(if_a_a), 0); chk("r1.c1.if_oe", int'(if_oe_a), 1);
          chk("r1.c1.busy", int'(busy_a), 1); chk("r1.c1.w_update", int'(w_update_a), 0);
        end
        2:  chk("r1.c2.w_update", int'(w_update_a), 1);
        8:  chk("r1.c8.lr_step", int'(lr_step_a), 0);
        9: begin
          chk("r1.c9.lr_step", int'(lr_step_a), 1); chk("r1.c9.epoch", int'(epoch_a), 1);
          chk("r1.c9.if_a", int'(if_a_a), 0);       chk("b.c9.lr_step", int'(lr_step_b), 1);
        end
        14: chk("b.c14.res_we", int'(res_we_b), 0);
        15: begin
          chk("b.c15.res_we", int'(res_we_b), 1); chk("b.c15.res_a", int'(res_a_b), 0);
        end
        17: begin
          chk("r1.c17.lr_step", int'(lr_step_a), 1); chk("r1.c17.w_we", int'(w_we_a), 1);
          chk("r1.c17.w_a", int'(w_a_a), 0);         chk("r1.c17.if_oe", int'(if_oe_a), 0);
          chk("b.c17.lr_step", int'(lr_step_b), 0);
        end
        19: chk("r1.c19.w_a", int'(w_a_a), 2);
        20: begin
          chk("r1.c20.if_a", int'(if_a_a), 0); chk("r1.c20.if_oe", int'(if_oe_a), 1);
        end
        22: chk("b.c22.done", int'(done_b), 0);
        23: chk("b.c23.done", int'(done_b), 1);
        28: begin
          chk("r1.c28.res_a", int'(res_a_a), 7); chk("r1.c28.done", int'(done_a), 0);
        end
        29: begin
          chk("r1.c29.done", int'(done_a), 1); chk("r1.c29.busy", int'(busy_a), 0);
        end
        default: ;
      endcase
    end

    // Run 2: restart from DONE, 3-cycle stall after MAP read 5
    start = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      start = 1'b0;
      stall_a = (c >= 25 && c <= 27);
      case (c)
        1: begin
          chk("r2.c1.done", int'(done_a), 0); chk("r2.c1.epoch", int'(epoch_a), 0);
          chk("r2.c1.if_a", int'(if_a_a), 0);
        end
        25: chk("r2.c25.if_a", int'(if_a_a), 5);
        26: begin
          chk("r2.c26.if_oe", int'(if_oe_a), 0); chk("r2.c26.if_a", int'(if_a_a), 5);
          chk("r2.c26.res_we", int'(res_we_a), 0); chk("r2.c26.res_a", int'(res_a_a), 4);
        end
        28: chk("r2.c28.if_oe", int'(if_oe_a), 0);
        29: begin
          chk("r2.c29.if_a", int'(if_a_a), 6); chk("r2.c29.res_a", int'(res_a_a), 5);
          chk("r2.c29.if_oe", int'(if_oe_a), 1);
        end
        31: chk("r2.c31.done", int'(done_a), 0);
        32: chk("r2.c32.done", int'(done_a), 1);
        default: ;
      endcase
    end

    // Run 3: asynchronous reset in the middle of MAP
    start = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("r3.c22.if_a", int'(if_a_a), 2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst.busy", int'(busy_a), 0);   chk("rst.if_oe", int'(if_oe_a), 0);
    chk("rst.if_a", int'(if_a_a), 0);   chk("rst.res_a", int'(res_a_a), 0);
    chk("rst.w_a", int'(w_a_a), 0);     chk("rst.epoch", int'(epoch_a), 0);
    chk("rst.busy_b", int'(busy_b), 0); chk("rst.res_we", int'(res_we_a), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("post.if_oe", int'(if_oe_a), 0);
    chk("post.busy", int'(busy_a), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
